// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 435,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rxd,
  output logic [7:0]            rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ferr,
  output logic                  ovf,
  input  logic                  err_clr
);
  localparam logic [31:0]         HALF     = 32'(CLK_PER_HALF_BIT);
  localparam logic [31:0]         FULL     = 32'(2 * CLK_PER_HALF_BIT);
  localparam int                  N        = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(N);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                r_state;
  logic [1:0]            r_sync;
  logic [31:0]           r_cnt;
  logic [2:0]            r_bit;
  logic [7:0]            r_shift;
  logic [7:0]            r_mem [N];
  logic [DEPTH_LOG2-1:0] r_wp, r_rp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ferr, r_ovf;

  logic w_rxd_s, w_stop_tick, w_full, w_pop, w_push, w_drop;

  assign w_rxd_s     = r_sync[1];
  assign w_stop_tick = (r_state == STOP) && (r_cnt == FULL - 1);
  assign w_full      = r_count == FULL_CNT;
  assign w_pop       = rvalid && rready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept the byte.
  assign w_push      = w_stop_tick && w_rxd_s && (!w_full || w_pop);
  assign w_drop      = w_stop_tick && w_rxd_s && w_full && !w_pop;

  always_ff @(posedge clk)
    if (!rstn) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rxd};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        IDLE: if (!w_rxd_s) begin
          r_state <= START;
          r_cnt   <= '0;
          r_bit   <= '0;
        end
        START: if (r_cnt == HALF - 1) begin
          r_cnt   <= '0;
          r_state <= w_rxd_s ? IDLE : DATA;
        end else r_cnt <= r_cnt + 1;
        DATA: if (r_cnt == FULL - 1) begin
          r_cnt   <= '0;
          r_shift <= {w_rxd_s, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= STOP;
        end else r_cnt <= r_cnt + 1;
        STOP: if (w_stop_tick) begin
          r_cnt   <= '0;
          r_state <= w_rxd_s ? IDLE : WAIT_IDLE;
        end else r_cnt <= r_cnt + 1;
        WAIT_IDLE: if (w_rxd_s) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= r_shift;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_count <= r_count + (DEPTH_LOG2 + 1)'(w_push) - (DEPTH_LOG2 + 1)'(w_pop);
      r_ferr  <= (w_stop_tick && !w_rxd_s) || (r_ferr && !err_clr);
      r_ovf   <= w_drop || (r_ovf && !err_clr);
    end
  end

  assign rdata  = r_mem[r_rp];
  assign rvalid = r_count != '0;
  assign count  = r_count;
  assign ferr   = r_ferr;
  assign ovf    = r_ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vector table, corner sequences and randomized frames against a queue-based model.
module tb_uart_rx_fifo;
  localparam int H = 4;
  localparam int D = 4;

  logic       clk = 1'b0, rstn = 1'b0, rxd = 1'b1, rready = 1'b0, err_clr = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, ferr, ovf;
  logic [D:0] count;

  uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DEPTH_LOG2(D)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .count(count), .ferr(ferr), .ovf(ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         good;
    int         stop_len;
    int         exp_count;
    bit         exp_ferr;
    bit         exp_ovf;
    logic [7:0] exp_head;
  } vec_t;
  vec_t vecs[3];

  always @(negedge clk)
    if (mon_en && rvalid && rready) got_q.push_back(rdata);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; rxd = 1'b1; rready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
  endtask

  // One frame: 8-cycle start, 8 data bits of 8 cycles, stop of stop_len cycles; a bad stop holds the line low 40 more cycles.
  task automatic send(input logic [7:0] b, input bit good, input int stop_len, input bit pop_at_stop);
    for (int t = 0; t < 72 + stop_len; t++) begin
      rxd = (t < 8) ? 1'b0 : (t < 72) ? b[(t - 8) / 8] : good;
      if (pop_at_stop) rready = (t == 78);
      tick();
    end
    if (pop_at_stop) rready = 1'b0;
    if (!good) begin
      rxd = 1'b0;
      repeat (40) tick();
    end
    rxd = 1'b1;
    repeat (good ? 4 : 80) tick();
  endtask

  task automatic drain(input string name);
    rready = 1'b1;
    foreach (exp_q[i]) begin
      check({name, "_rvalid"}, rvalid, 1);
      check({name, "_rdata"}, rdata, exp_q[i]);
      tick();
    end
    rready = 1'b0;
    check({name, "_empty"}, rvalid, 0);
  endtask

  task automatic clear_errs;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8, 1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h55, 1'b0, 8, 1, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 7, 2, 1'b1, 1'b0, 8'hA5};

    do_reset();
    check("reset_rvalid", rvalid, 0);
    check("reset_count", count, 0);
    check("reset_ferr", ferr, 0);
    check("reset_ovf", ovf, 0);

    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].good, vecs[i].stop_len, 1'b0);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].exp_count != 0);
      check($sformatf("vec%0d_ferr", i), ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      check($sformatf("vec%0d_head", i), rdata, vecs[i].exp_head);
    end
    clear_errs();
    check("errclr_ferr", ferr, 0);
    check("errclr_count", count, 2);
    exp_q = '{8'hA5, 8'h3C};
    drain("vec_drain");

    do_reset();
    rready = 1'b1;
    got_q.delete();
    mon_en = 1'b1;
    send(8'h00, 1'b1, 7, 1'b0);
    send(8'hFF, 1'b1, 7, 1'b0);
    send(8'h3C, 1'b1, 7, 1'b0);
    repeat (5) tick();
    mon_en = 1'b0;
    rready = 1'b0;
    check("b2b_n", got_q.size(), 3);
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    foreach (exp_q[i]) check($sformatf("b2b_pop%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
    check("b2b_ferr", ferr, 0);
    check("b2b_ovf", ovf, 0);
    check("b2b_count", count, 0);

    do_reset();
    for (int i = 1; i <= 17; i++) send(8'(i), 1'b1, 8, 1'b0);
    check("ovf_count", count, 16);
    check("ovf_flag", ovf, 1);
    check("ovf_ferr", ferr, 0);
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    drain("ovf_drain");

    do_reset();
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (30) tick();
    check("glitch_count", count, 0);
    check("glitch_ferr", ferr, 0);
    send(8'h81, 1'b1, 8, 1'b0);
    check("glitch_after_count", count, 1);
    check("glitch_after_head", rdata, 8'h81);

    do_reset();
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b1, 8, 1'b0);
    send(8'h77, 1'b1, 8, 1'b1);
    check("fullpop_count", count, 16);
    check("fullpop_ovf", ovf, 0);
    exp_q.delete();
    for (int i = 2; i <= 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h77);
    drain("fullpop_drain");

    send(8'h42, 1'b1, 8, 1'b0);
    send(8'h00, 1'b0, 8, 1'b0);
    check("prerst_count", count, 1);
    check("prerst_ferr", ferr, 1);
    rxd = 1'b0;
    repeat (20) tick();
    rstn = 1'b0;
    repeat (2) tick();
    check("midrst_rvalid", rvalid, 0);
    check("midrst_count", count, 0);
    check("midrst_ferr", ferr, 0);
    check("midrst_ovf", ovf, 0);
    rxd = 1'b1;
    rstn = 1'b1;
    repeat (100) tick();
    check("postrst_count", count, 0);
    check("postrst_ferr", ferr, 0);

    for (int r = 0; r < 3; r++) begin
      int  n;
      bit  ef, eo;
      do_reset();
      exp_q.delete();
      ef = 1'b0;
      eo = 1'b0;
      n = $urandom_range(8, 22);
      for (int k = 0; k < n; k++) begin
        logic [7:0] b;
        bit         good;
        int         sl;
        b    = 8'($urandom);
        good = $urandom_range(0, 7) != 0;
        sl   = ($urandom_range(0, 2) == 0) ? 7 : ($urandom_range(0, 1) == 0) ? 8 : 12;
        send(b, good, sl, 1'b0);
        if (!good) ef = 1'b1;
        else if (exp_q.size() < 16) exp_q.push_back(b);
        else eo = 1'b1;
      end
      check($sformatf("rnd%0d_count", r), count, exp_q.size());
      check($sformatf("rnd%0d_ferr", r), ferr, ef);
      check($sformatf("rnd%0d_ovf", r), ovf, eo);
      drain($sformatf("rnd%0d_drain", r));
      clear_errs();
      check($sformatf("rnd%0d_clr_ferr", r), ferr, 0);
      check($sformatf("rnd%0d_clr_ovf", r), ovf, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
